// File: rtl/xor_descrambler.sv
// Descrambles a 32-bit word stream by XOR with a Galois LFSR keystream.
// The keystream advances once per accepted word; output is a one-deep registered stage.
module xor_descrambler #(
  parameter logic [31:0] TAPS = 32'h80200003
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        seed_load,
  input  logic [31:0] seed,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic [15:0] word_count,
  output logic        busy
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] lfsr;
  logic [31:0] lfsr_step;
  logic        xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every
      // register samples pre-edge values regardless of block ordering.
      state <= state_next;
    end
  end

  // RUN is absorbing; only reset returns the block to IDLE.
  always_comb begin
    state_next = state;
    if (seed_load) state_next = RUN;
  end

  assign busy      = (state == RUN);
  assign in_ready  = busy & ~seed_load & (~out_valid | out_ready);
  assign xfer      = in_valid & in_ready;
  assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 32'h0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr       <= 32'h00000001;
      word_count <= 16'h0000;
    end else if (seed_load) begin
      // An all-zero Galois LFSR would never leave zero, so substitute 1.
      lfsr       <= (seed == 32'h0) ? 32'h00000001 : seed;
      word_count <= 16'h0000;
    end else if (xfer) begin
      lfsr       <= lfsr_step;
      word_count <= word_count + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: out_data is reset too because reset must expose a zero output
      // word; a wide datapath register without that need could skip reset.
      out_valid <= 1'b0;
      out_data  <= 32'h0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data ^ lfsr;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xor_descrambler.sv
// Directed and randomized round-trip checks for xor_descrambler.
// Inputs change 1 ns after each rising edge; outputs are sampled 1 ns later.
module tb_xor_descrambler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        seed_load = 1'b0;
  logic [31:0] seed = 32'h0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic [15:0] word_count;
  logic        busy;

  int checks = 0;
  int fails  = 0;

  xor_descrambler dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seed_load (seed_load),
    .seed      (seed),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .word_count(word_count),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_seed(input logic [31:0] s);
    seed_load = 1'b1;
    seed      = s;
    tick();
    seed_load = 1'b0;
  endtask

  function automatic logic [31:0] model_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h80200003 : 32'h0);
  endfunction

  logic [31:0] exp_q[$];
  logic [31:0] m_lfsr;
  logic [31:0] orig;
  logic [31:0] exp_word;

  initial begin
    // Reset and idle behaviour
    #1 rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_word_count", word_count, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 0);
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    out_ready = 1'b1;
    tick();
    check("idle_in_ready", in_ready, 0);
    tick();
    check("idle_no_xfer", out_valid, 0);
    check("idle_count", word_count, 0);

    // Basic vectors, seed 1
    in_valid = 1'b0;
    load_seed(32'h00000001);
    check("seed1_busy", busy, 1);
    check("seed1_count", word_count, 0);
    in_valid = 1'b1;
    in_data  = 32'hFFFFFFFF;
    #1 check("seed1_in_ready", in_ready, 1);
    tick();
    check("seed1_w0_valid", out_valid, 1);
    check("seed1_w0", out_data, 32'hFFFFFFFE);
    in_data = 32'h80200003;
    tick();
    check("seed1_w1", out_data, 32'h00000000);
    check("seed1_count2", word_count, 2);
    in_valid = 1'b0;
    tick();
    check("seed1_drained", out_valid, 0);

    // Seed 0 behaves as seed 1
    load_seed(32'h00000000);
    in_valid = 1'b1;
    in_data  = 32'hFFFFFFFF;
    tick();
    check("seed0_w0", out_data, 32'hFFFFFFFE);
    in_data = 32'h80200003;
    tick();
    check("seed0_w1", out_data, 32'h00000000);
    check("seed0_count2", word_count, 2);
    in_valid = 1'b0;
    tick();

    // Back-pressure: output held, keystream frozen
    load_seed(32'h00000001);
    in_valid  = 1'b1;
    in_data   = 32'h00000000;
    out_ready = 1'b0;
    tick();
    in_data = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", in_ready, 0);
      check("bp_out_data", out_data, 32'h00000001);
      check("bp_out_valid", out_valid, 1);
      tick();
    end
    check("bp_count", word_count, 1);
    out_ready = 1'b1;
    in_data   = 32'h80200003;
    #1 check("bp_release_ready", in_ready, 1);
    tick();
    check("bp_resume", out_data, 32'h00000000);
    check("bp_resume_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();

    // Reseed while an output is pending and an input is offered
    load_seed(32'h00000001);
    in_valid  = 1'b1;
    in_data   = 32'h0F0F0F0F;
    out_ready = 1'b0;
    tick();
    check("pend_word", out_data, 32'h0F0F0F0E);
    seed_load = 1'b1;
    seed      = 32'hA5A5A5A5;
    in_data   = 32'h11111111;
    #1 check("reseed_in_ready", in_ready, 0);
    tick();
    seed_load = 1'b0;
    check("reseed_count", word_count, 0);
    check("reseed_pend_valid", out_valid, 1);
    check("reseed_pend_data", out_data, 32'h0F0F0F0E);
    out_ready = 1'b1;
    in_data   = 32'hFFFFFFFF;
    tick();
    check("reseed_w0", out_data, 32'h5A5A5A5A);
    check("reseed_w0_count", word_count, 1);
    in_data = 32'h00000000;
    tick();
    check("reseed_w1", out_data, 32'hD2F2D2D1);
    check("reseed_w1_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();

    // Randomized round trip with stalls on both sides
    m_lfsr = 32'h3C5A9617;
    load_seed(m_lfsr);
    begin
      int sent = 0;
      int cyc  = 0;
      while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
        in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
        orig      = $urandom;
        in_data   = orig ^ m_lfsr;
        out_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (out_valid && out_ready) begin
          check("rt_queue_nonempty", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            exp_word = exp_q.pop_front();
            check("rt_word", out_data, exp_word);
          end
        end
        if (in_valid && in_ready) begin
          exp_q.push_back(orig);
          m_lfsr = model_step(m_lfsr);
          sent++;
        end
        tick();
        cyc++;
      end
      check("rt_all_sent", sent, 1000);
      check("rt_all_drained", exp_q.size(), 0);
      check("rt_count", word_count, 1000);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();

    // word_count wraps after 65536 transfers
    load_seed(32'h00000001);
    in_valid = 1'b1;
    in_data  = 32'h0;
    repeat (65535) tick();
    check("wrap_ffff", word_count, 16'hFFFF);
    tick();
    check("wrap_zero", word_count, 16'h0000);
    check("wrap_valid", out_valid, 1);
    in_valid = 1'b0;
    tick();

    // Asynchronous reset mid-stream
    load_seed(32'h00000001);
    in_valid  = 1'b1;
    in_data   = 32'hCAFEF00D;
    out_ready = 1'b0;
    tick();
    check("mid_pend_valid", out_valid, 1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_out_data", out_data, 0);
    check("async_in_ready", in_ready, 0);
    check("async_busy", busy, 0);
    tick();
    rst_n     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    tick();
    check("post_rst_in_ready", in_ready, 0);
    check("post_rst_valid", out_valid, 0);
    check("post_rst_count", word_count, 0);
    load_seed(32'h00000001);
    in_data = 32'hFFFFFFFF;
    tick();
    check("post_rst_w0", out_data, 32'hFFFFFFFE);
    in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/xor_descrambler.md
XOR_DESCRAMBLER -- requirements
Module: xor_descrambler

Interface
REQ-001 Parameter TAPS, default 32'h80200003: Galois LFSR feedback mask.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 seed_load  input  1  one-cycle pulse; loads LFSR from seed and enters RUN.
REQ-005 seed  input  32  keystream seed, sampled when seed_load=1.
REQ-006 in_valid  input  1  scrambled word present on in_data.
REQ-007 in_data  input  32  scrambled word.
REQ-008 in_ready  output  1  block accepts in_data this cycle.
REQ-009 out_valid  output  1  out_data holds a descrambled word.
REQ-010 out_data  output  32  descrambled word.
REQ-011 out_ready  input  1  downstream accepts out_data this cycle.
REQ-012 word_count  output  16  number of words accepted since last seed_load.
REQ-013 busy  output  1  1 when state is RUN.

Function
REQ-014 The FSM SHALL have two states: IDLE and RUN; IDLE->RUN on seed_load=1; RUN stays RUN (a further seed_load reseeds and stays in RUN); no other transitions except reset.
REQ-015 On seed_load=1 the LFSR SHALL load seed, or 32'h00000001 when seed==0 (all-zero lock-up avoided), and word_count SHALL clear to 0.
REQ-016 in_ready SHALL equal (state==RUN) & !seed_load & (!out_valid | out_ready), combinationally.
REQ-017 A transfer SHALL occur when in_valid & in_ready; on it, out_data <= in_data ^ lfsr, out_valid <= 1, word_count <= word_count+1.
REQ-018 On each transfer the LFSR SHALL advance one step: lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0); it SHALL NOT advance otherwise.
REQ-019 Latency SHALL be exactly 1 cycle: a word accepted at edge N is on out_data with out_valid=1 after edge N.
REQ-020 Output handshake: out_valid, out_data SHALL hold stable while out_valid & !out_ready; out_valid SHALL clear on out_valid & out_ready with no new transfer that cycle.
REQ-021 Simultaneous drain and accept (out_valid & out_ready & in_valid & in_ready) SHALL replace out_data with the new word, out_valid stays 1; full throughput 1 word/cycle.
REQ-022 seed_load SHALL have priority over an input transfer; the input word that cycle is not consumed (in_ready=0).
REQ-023 seed_load SHALL NOT disturb a pending output word; it remains valid until drained.
REQ-024 word_count SHALL wrap 16'hFFFF -> 16'h0000 without other side effects.
REQ-025 In IDLE, in_ready SHALL be 0 and no LFSR or counter change SHALL occur except via seed_load.

Reset
REQ-026 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, lfsr=32'h00000001, out_valid=0, out_data=0, word_count=0, busy=0, in_ready=0.
REQ-027 Reset asserted mid-stream SHALL discard any pending output word; after release, no transfer occurs until a new seed_load.
REQ-028 Reset release SHALL take effect at the first rising clk edge with rst_n=1.

Verification
REQ-029 seed_load, seed=0x00000001; then in_data=0xFFFFFFFF, out_ready=1 -> out_data=0xFFFFFFFE one cycle later; next in_data=0x80200003 -> out_data=0x00000000; word_count=2.
REQ-030 seed=0x00000000 loaded -> behaviour identical to seed 0x00000001 (same outputs as REQ-029 vectors).
REQ-031 Back-pressure: out_ready=0 with out_valid=1 -> in_ready=0, out_data stable for 5 cycles, LFSR not advanced; releasing out_ready resumes with correct keystream.
REQ-032 seed_load coincident with in_valid=1 -> word not accepted, word_count=0, next accepted word XORed with new seed.
REQ-033 Round trip: 1000 random words scrambled by a reference XOR-LFSR model with same seed, random valid/ready stalls -> outputs equal originals in order; word_count wrap checked by preloading 65535 transfers -> 0.
REQ-034 rst_n pulsed low mid-stream with out_valid=1 -> out_valid=0 asynchronously, in_ready=0 until seed_load.
